// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one single-precision multiplier among NREQ requesters.
// Returns the product with sign and zero cases fixed up, tagged with the requester index.
module fp_mul_sched #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*32-1:0]            req_a,
    input  logic [NREQ*32-1:0]            req_b,
    output logic [NREQ-1:0]               req_ready,
    output logic [31:0]                   mul_a,
    output logic [31:0]                   mul_b,
    input  logic [31:0]                   mul_p,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [31:0]                   rsp_data,
    input  logic                          rsp_ready
);

    localparam int DATA_W = 32;
    localparam int ID_W   = $clog2(NREQ);
    localparam int CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                     state, state_nxt;
    logic        [ID_W-1:0]     rr_ptr;
    logic        [CNT_W-1:0]    cnt;
    logic signed [DATA_W-1:0]   op_a, op_b;
    logic        [ID_W-1:0]     gnt_idx;
    logic                       gnt_found;
    logic                       acc;

    // The multiplier's own sign is discarded; the sign is recomputed from the operands.
    logic unused_mul_sign;
    assign unused_mul_sign = mul_p[31];

    function automatic logic [DATA_W-1:0] fix_product(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b,
                                                      input logic [DATA_W-1:0] p);
        logic s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return {s, 31'b0};
        return {s, p[30:0]};
    endfunction

    // Arbitration: first valid requester searching upward from rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_valid[rr_ptr + ID_W'(i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_ptr + ID_W'(i);
            end
        end
    end

    assign acc = (state == IDLE) && gnt_found;

    always_comb begin
        req_ready = '0;
        if (rst_n && acc)
            req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand capture on accept, settle count in BUSY, result capture at count zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    op_a   <= req_a[32*int'(gnt_idx) +: 32];
                    op_b   <= req_b[32*int'(gnt_idx) +: 32];
                    rsp_id <= gnt_idx;
                    rr_ptr <= gnt_idx + ID_W'(1);
                    cnt    <= CNT_W'(MUL_LAT - 1);
                end
                BUSY: begin
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                    else
                        rsp_data <= fix_product(op_a, op_b, mul_p);
                end
                default: ;
            endcase
        end
    end

    assign mul_a     = op_a;
    assign mul_b     = op_b;
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_fp_mul_sched.sv
// Scoreboard bench for fp_mul_sched: a behavioural multiplier that ignores sign and zero,
// expected results queued at each accept and compared at each response handshake.
module tb_fp_mul_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ready;
    logic [31:0]  mul_a, mul_b, mul_p;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_ready;

    logic [3:0]   r3_valid;
    logic [127:0] r3_a, r3_b;
    logic [3:0]   r3_ready;
    logic [31:0]  mul3_a, mul3_b, mul3_p;
    logic         rsp3_valid;
    logic [1:0]   rsp3_id;
    logic [31:0]  rsp3_data;
    logic         rsp3_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [33:0] sb_q[$];
    logic [33:0] sb_e;
    int          gnt_q[$];
    int          gnt_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Deliberately sign-blind and zero-blind, like the real shared unit.
    function automatic logic [31:0] tb_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {1'b0, e[7:0], m};
    endfunction

    function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        p = tb_mul(a, b);
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return {a[31] ^ b[31], 31'b0};
        return {a[31] ^ b[31], p[30:0]};
    endfunction

    assign mul_p  = tb_mul(mul_a, mul_b);
    assign mul3_p = tb_mul(mul3_a, mul3_b);

    fp_mul_sched #(.NREQ(4), .MUL_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    fp_mul_sched #(.NREQ(4), .MUL_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_a(r3_a), .req_b(r3_b),
        .req_ready(r3_ready), .mul_a(mul3_a), .mul_b(mul3_b), .mul_p(mul3_p),
        .rsp_valid(rsp3_valid), .rsp_id(rsp3_id), .rsp_data(rsp3_data), .rsp_ready(rsp3_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: push at every accept, pop at every response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (req_ready != 4'b0000) begin
                chk("onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i] && req_valid[i]) begin
                        sb_q.push_back({2'(i), exp_res(req_a[32*i +: 32], req_b[32*i +: 32])});
                        gnt_q.push_back(i);
                        gnt_t.push_back(cyc);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(sb_e[33:32]));
                    chk("sb_data", rsp_data, sb_e[31:0]);
                end
            end
        end
    end

    task automatic wait_grant(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 32'(req_ready[id]), 32'd1);
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d);
        int n;
        @(posedge clk); #1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id] = 1'b1;
        wait_grant(id);
        chk("gnt_vec", 32'(req_ready), 32'(4'b0001 << id));
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        n = 1;
        @(negedge clk);
        chk("gnt_one_cycle", 32'(req_ready), 32'd0);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd2);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_data", rsp_data, exp_d);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] d0, a, b;
        logic [1:0]  i0;
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        r3_valid = '0; r3_a = '0; r3_b = '0; rsp3_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(2, 32'h40000000, 32'h40400000, 32'h40C00000);
        do_op(0, 32'hC0000000, 32'h40400000, 32'hC0C00000);
        do_op(1, 32'hC0000000, 32'hC0400000, 32'h40C00000);
        do_op(3, 32'h00000000, 32'h40400000, 32'h00000000);
        do_op(2, 32'h80000000, 32'h40400000, 32'h80000000);
        do_op(1, 32'h3F800000, 32'h00000000, 32'h00000000);

        for (int k = 0; k < 8; k++) begin
            a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
            do_op(int'($urandom_range(0, 3)), a, b, exp_res(a, b));
        end

        // Backpressure: response held, no accept while a second requester waits.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_a[32 +: 32] = 32'h40000000; req_b[32 +: 32] = 32'h40400000;
        req_valid[1] = 1'b1;
        wait_grant(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_a[96 +: 32] = 32'h3FC00000; req_b[96 +: 32] = 32'h40000000;
        req_valid[3] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        d0 = rsp_data;
        i0 = rsp_id;
        chk("bp_data", d0, 32'h40C00000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data_stable", rsp_data, d0);
            chk("bp_id_stable", 32'(rsp_id), 32'(i0));
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hs_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second", rsp_data, 32'h40400000);
        @(posedge clk); #1;

        // Abort: reset while BUSY.
        req_a[0 +: 32] = 32'h40000000; req_b[0 +: 32] = 32'h40400000;
        req_valid[0] = 1'b1;
        wait_grant(0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_mul_a", mul_a, 32'd0);
        chk("abort_mul_b", mul_b, 32'd0);
        chk("abort_rsp_id", 32'(rsp_id), 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Fairness: all four valid, arbitration restarts at 0 after reset.
        gnt_q.delete();
        gnt_t.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h3F800000 + 32'(i << 20);
            req_b[32*i +: 32] = 32'h40000000 + 32'(i << 18);
        end
        req_valid = 4'b1111;
        n = 0;
        while (gnt_q.size() < 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("fair_count", 32'(gnt_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < gnt_q.size(); k++) begin
            chk("fair_order", 32'(gnt_q[k]), 32'(k % 4));
            if (k > 0)
                chk("fair_gap", 32'(gnt_t[k] - gnt_t[k-1]), 32'd3);
        end
        repeat (6) @(negedge clk);

        // MUL_LAT=3 instance: response four cycles after accept.
        @(posedge clk); #1;
        r3_a[32 +: 32] = 32'h40000000; r3_b[32 +: 32] = 32'h40400000;
        r3_valid[1] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!r3_ready[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat3_grant", 32'(r3_ready), 32'b0010);
        @(posedge clk); #1;
        r3_valid[1] = 1'b0;
        n = 1;
        @(negedge clk);
        while (!rsp3_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat3_latency", 32'(n), 32'd4);
        chk("lat3_id", 32'(rsp3_id), 32'd1);
        chk("lat3_data", rsp3_data, 32'h40C00000);

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_sched.md
# fp_mul_sched

Round-robin scheduler that shares one `fp_mul` single-precision multiplier among `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and registers the operands onto the shared multiplier. After a fixed settle time it captures the product, fixes up the sign and zero cases the multiplier does not handle, and returns the result tagged with the requester index. It sits between the requesting datapath lanes and the single multiplier instance.

## Interface
- `NREQ`, 4 — number of requesters; fixed at 4, so the ID width is 2.
- `MUL_LAT`, 1 — cycles the multiplier output is given to settle before capture; must be at least 1.

- `clk` in 1 — the single clock; all state is updated on its rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `req_valid` in NREQ — per-requester operand valid.
- `req_a` in NREQ*32 — packed operand A; requester i uses bits [32i+31:32i].
- `req_b` in NREQ*32 — packed operand B, same packing as `req_a`.
- `req_ready` out NREQ — one-hot grant, or all zero.
- `mul_a` out 32 — operand A to the shared multiplier, driven from a register.
- `mul_b` out 32 — operand B to the shared multiplier, driven from a register.
- `mul_p` in 32 — product returned by the shared multiplier.
- `rsp_valid` out 1 — result valid.
- `rsp_id` out 2 — index of the requester that owns the result.
- `rsp_data` out 32 — final IEEE-754 single-precision product.
- `rsp_ready` in 1 — consumer accepts the result.

## Operation
- **FSM states:** IDLE, BUSY, RESP.
- **IDLE:**
  - If any `req_valid` is set, grant g = the first valid index found by searching upward from `rr_ptr`, wrapping modulo NREQ.
  - `req_ready[g]` = 1 combinationally in the same cycle; the handshake completes that cycle.
  - On that edge, latch `op_a`/`op_b` ← `req_a[g]`/`req_b[g]`, `rsp_id` ← g, `rr_ptr` ← (g+1) mod NREQ, `cnt` ← MUL_LAT-1, then go to BUSY.
- **BUSY:**
  - `mul_a` = `op_a` and `mul_b` = `op_b`, held stable.
  - If `cnt` ≠ 0, decrement `cnt`.
  - If `cnt` = 0, capture the fixed-up product into `rsp_data` and go to RESP.
- **RESP:**
  - `rsp_valid` = 1, with `rsp_data` and `rsp_id` held stable.
  - When `rsp_ready` = 1, the handshake completes and the FSM goes to IDLE.
- **Fix-up on capture:**
  - sign s = `op_a[31]` ^ `op_b[31]`.
  - If `op_a[30:23]` = 0 or `op_b[30:23]` = 0, `rsp_data` = {s, 31'b0}.
  - Otherwise `rsp_data` = {s, `mul_p[30:0]`}.
  - No NaN, infinity, overflow or denormal handling; those inputs give undefined results.
- `req_ready` is all zero outside IDLE; requesters not granted keep `req_valid` and their operands stable.
- `rr_ptr` advances only on an accept, so a requester that stays valid is served within NREQ operations.

## Timing
- **Reset values:**
  - state = IDLE, `rr_ptr` = 0, `cnt` = 0.
  - `op_a`, `op_b`, `mul_a`, `mul_b` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
  - `req_ready` is forced to 0 while `rst_n` is low.
- **Latency:** an accept on edge T gives `rsp_valid` = 1 in the cycle after edge T+MUL_LAT.
- **Throughput:** with `rsp_ready` tied high, one operation completes every MUL_LAT+2 cycles.
- **Simultaneous requests:** exactly one grant per accept. There is no accept in BUSY or RESP, including the cycle in which RESP completes its handshake.
- **Reset mid-operation:** the in-flight operation is discarded and no response is produced. After `rst_n` is released, arbitration restarts at index 0.
- **Backpressure:** RESP holds indefinitely while `rsp_ready` = 0, and no new operand is accepted during that time.

## Test plan
- **Single request:** MUL_LAT=1; requester 2 presents a=0x40000000, b=0x40400000. Required: `req_ready` = 4'b0100 for one cycle, then `rsp_valid` two cycles after the accept with `rsp_id`=2 and `rsp_data`=0x40C00000 (6.0).
- **Sign fix-up:** a=0xC0000000, b=0x40400000 gives `rsp_data`=0xC0C00000. a=0xC0000000, b=0xC0400000 gives 0x40C00000.
- **Zero fix-up:** a=0x00000000, b=0x40400000 gives 0x00000000. a=0x80000000, b=0x40400000 gives 0x80000000.
- **Fairness:** all four requesters held valid, `rsp_ready`=1. Required: grant order 0,1,2,3,0,1, with a gap of MUL_LAT+2 cycles between accepts.
- **Backpressure:** `rsp_ready`=0 for 5 cycles. Required: `rsp_valid`, `rsp_data` and `rsp_id` stay stable and `req_ready` stays 0. Once `rsp_ready` rises, the next grant comes one cycle after the response handshake.
- **Abort and latency:** assert `rst_n`=0 during BUSY. Required: `rsp_valid` never rises and all outputs return to their reset values immediately. Separately, with MUL_LAT=3, the response appears four cycles after the accept.
